// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam int DEF_CLKS_PER_BIT = 1;
  localparam int DEF_DATA_BITS    = 8;

  // Mid-bit offset in clocks from the detected start edge.
  function automatic int half_of(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop RXD synchroniser plus falling-edge detect; all flops idle high.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic rxd_s,
  output logic start_edge
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rxd;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rxd_s      = sync_q;
  // Edge only: a line parked low never restarts reception.
  assign start_edge = ~sync_q & prev_q;
endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: mid-bit sampling, parallel word out with valid
// strobe, and a frame-error strobe when the stop bit reads low.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_frame_err
);
  localparam int HALF = half_of(CLKS_PER_BIT);
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rxd_s, start_edge;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .rxd        (RXD),
    .rxd_s      (rxd_s),
    .start_edge (start_edge)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS:0]   shifted;

  // LSB-first: each new bit enters at the top, so after DATA_BITS shifts
  // the first bit received lands in bit 0.
  assign shifted = {rxd_s, shift_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          idx_d = '0;
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = START;
            cnt_d   = CW'(1);
          end
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = shifted[DATA_BITS:1];
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = busy_q;
  assign rx_frame_err = ferr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench: two receivers (1 and 16 clocks/bit) fed serial frames;
// a monitor pops expected words/errors and their arrival cycle.
module tb_uart_receiver;
  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd_a = 1'b1, rxd_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic valid_a, valid_b, busy_a, busy_b, ferr_a, ferr_b;

  int checks = 0, errors = 0;
  int cyc = 0;
  int bcnt_a = 0, bcnt_b = 0;
  exp_t qa[$], qb[$];
  logic [7:0] lg[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver dut_a (
    .clk(clk), .reset(reset), .RXD(rxd_a), .rx_data(data_a),
    .rx_valid(valid_a), .rx_busy(busy_a), .rx_frame_err(ferr_a)
  );

  uart_receiver #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut_b (
    .clk(clk), .reset(reset), .RXD(rxd_b), .rx_data(data_b),
    .rx_valid(valid_b), .rx_busy(busy_b), .rx_frame_err(ferr_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic e, input logic [7:0] d);
    exp_t x;
    int sz;
    if (!(v || e)) return;
    sz = (w == 0) ? qa.size() : qb.size();
    if (sz == 0) begin
      chk($sformatf("unexpected_pulse_%0d", w), 1, 0);
      return;
    end
    if (w == 0) x = qa.pop_front(); else x = qb.pop_front();
    chk($sformatf("pulse_kind_%0d", w), int'(e), int'(x.err));
    chk($sformatf("both_pulses_%0d", w), int'(v & e), 0);
    chk($sformatf("rx_data_%0d", w), int'(d), int'(x.data));
    chk($sformatf("pulse_cycle_%0d", w), cyc, x.cyc);
  endtask

  always @(negedge clk) begin
    if (busy_a) bcnt_a++;
    if (busy_b) bcnt_b++;
    mon(0, valid_a, ferr_a, data_a);
    mon(1, valid_b, ferr_b, data_b);
  end

  task automatic drive(input int w, input logic b, input int cpb);
    if (w == 0) rxd_a = b; else rxd_b = b;
    repeat (cpb) @(negedge clk);
  endtask

  // Must be called at a negedge; the following posedge captures the start bit.
  task automatic send_frame(input int w, input logic [7:0] data, input bit stop, input int gap);
    int cpb;
    exp_t x;
    cpb   = (w == 0) ? 1 : 16;
    x.err = !stop;
    x.cyc = cyc + 1 + 2 + (cpb - 1) / 2 + 9 * cpb;
    if (stop) begin
      x.data = data;
      lg[w]  = data;
    end else begin
      x.data = lg[w];
    end
    if (w == 0) qa.push_back(x); else qb.push_back(x);
    drive(w, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(w, data[i], cpb);
    drive(w, stop, cpb);
    repeat (gap) drive(w, 1'b1, cpb);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((qa.size() + qb.size()) != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(name, qa.size() + qb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    lg[0] = 8'h00;
    lg[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", int'({data_a, valid_a, busy_a, ferr_a}), 0);
    chk("reset_outputs_b", int'({data_b, valid_b, busy_b, ferr_b}), 0);
    reset = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({data_a, valid_a, busy_a, ferr_a, data_b, valid_b, busy_b, ferr_b} != '0) bad = 1;
    end
    chk("idle_quiet", bad, 0);

    // Basic frame at 1 clock/bit.
    bcnt_a = 0;
    send_frame(0, 8'hAA, 1'b1, 4);
    chk("busy_len_a", bcnt_a, 9);

    // Back-to-back at 16 clocks/bit.
    send_frame(1, 8'h3C, 1'b1, 0);
    send_frame(1, 8'hC3, 1'b1, 2);
    drain("drain_b2b");

    // Short low glitch aborts at mid-start.
    repeat (4) @(negedge clk);
    bcnt_b = 0;
    rxd_b = 1'b0;
    repeat (3) @(negedge clk);
    rxd_b = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy_len", bcnt_b, 7);

    // Framing error, then a held-low line must not restart.
    send_frame(0, 8'h55, 1'b0, 0);
    repeat (5) @(negedge clk);
    bcnt_a = 0;
    repeat (40) @(negedge clk);
    chk("break_no_busy", bcnt_a, 0);
    drive(0, 1'b1, 2);
    send_frame(0, 8'h12, 1'b1, 2);

    // Random traffic on both receivers.
    repeat (24) begin
      int w, gap;
      bit stop;
      logic [7:0] d;
      w    = int'($urandom_range(1, 0));
      d    = 8'($urandom);
      stop = ($urandom_range(5, 0) != 0);
      gap  = int'($urandom_range(3, stop ? 0 : 1));
      send_frame(w, d, stop, gap);
    end
    drain("drain_random");

    // Asynchronous reset in the middle of a DATA bit.
    repeat (4) @(negedge clk);
    rxd_b = 1'b0;
    repeat (16) @(negedge clk);
    rxd_b = 1'b1;
    repeat (48) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("reset_mid_busy", int'(busy_b), 0);
    chk("reset_mid_data", int'(data_b), 0);
    lg[0] = 8'h00;
    lg[1] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(1, 8'h81, 1'b1, 2);
    drain("drain_after_reset");

    repeat (10) @(negedge clk);
    chk("final_idle", int'({busy_a, busy_b}), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
